mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS datapath (mult, div). It also owns the HI/LO registers read by mfhi and mflo.
- Operands come from the register-file A/B latches. The main FSM controller starts an operation and polls Busy/Done.
- Hi/Lo feed the write-back data mux downstream.
- One operation in flight at a time. Iterative shift-add multiply, restoring divide, sign-magnitude correction at the end.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low (0 = reset), sampled on the rising edge of Clk.
- A  input  WIDTH  multiplicand / dividend (register A output).
- B  input  WIDTH  multiplier / divisor (register B output).
- MultStart  input  1  request signed multiply; sampled only in IDLE or DONE.
- DivStart  input  1  request signed divide; sampled only in IDLE or DONE.
- Hi  output  WIDTH  HI register: product[2W-1:W] or remainder.
- Lo  output  WIDTH  LO register: product[W-1:0] or quotient.
- Busy  output  1  high in states MULT, DIV, FIX.
- Done  output  1  one-cycle completion pulse, high in state DONE.
- DivZero  output  1  high with Done when the completed divide had B = 0.

Behaviour:
- Reset (Reset = 0 at an edge):
  - state to IDLE; Hi, Lo and all internal registers to 0; Busy, Done, DivZero to 0.
  - Applies in any state: an operation in progress is aborted, no Done is produced, and Hi/Lo are cleared.
- States: IDLE, MULT, DIV, FIX, DONE.
- Capture edge E0 (state IDLE or DONE, Reset = 1):
  - MultStart = 1: latch |A|, |B|, sign flag = A[W-1] xor B[W-1]; clear partial product and counter; go to MULT.
  - DivStart = 1 (MultStart = 0), B != 0: latch |A| as dividend, |B| as divisor; quotient sign = A[W-1] xor B[W-1]; remainder sign = A[W-1]; clear remainder and counter; go to DIV.
  - DivStart = 1, B = 0: go to DONE with DivZero = 1. Hi/Lo are not modified. Done and DivZero are high in the cycle after E0.
  - MultStart and DivStart both high: multiply wins; DivStart is ignored.
  - Neither high: IDLE stays IDLE; DONE goes to IDLE.
- MULT, edges E1..E{WIDTH}: one shift-add step per edge on a 2W-bit accumulator. After WIDTH steps, go to FIX.
- DIV, edges E1..E{WIDTH}: one restoring step per edge.
  - Shift {rem, dividend} left by 1; trial-subtract the divisor.
  - If the result is non-negative, keep it and set quotient bit = 1; otherwise quotient bit = 0.
  - After WIDTH steps, go to FIX.
- FIX, edge E{WIDTH+1}: apply sign correction (two's-complement negate) and write Hi/Lo; go to DONE.
  - MULT: {Hi,Lo} = 2W-bit signed product.
  - DIV: Lo = quotient, truncated toward zero; Hi = remainder, taking the sign of the dividend.
  - Overflow case A = 0x80000000, B = 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0, with no flag.
- DONE: Done = 1 for exactly one cycle; Busy = 0.
  - A Start in this cycle is accepted (back-to-back operation); otherwise go to IDLE.
  - DivZero is cleared on leaving DONE.
- Latency: Done is high in the cycle following edge E0+WIDTH+1 (34 cycles after capture for WIDTH = 32). Divide-by-zero latency is 1.
- Start while Busy: ignored, with no effect on the operation or operands.
- A/B may change after E0 without affecting the result.
- Hi/Lo hold their value between operations. They are updated only at FIX or by reset.

Test Plan:
- A=7, B=0xFFFFFFFD, MultStart pulse -> Busy for 33 cycles; Done 1 cycle after E33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- A=100, B=0xFFFFFFF9 (-7), DivStart -> Lo=0xFFFFFFF2 (-14), Hi=0x00000002. Then A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- Corners:
  - A=B=0x80000000, multiply -> Hi=0x40000000, Lo=0.
  - A=0x80000000, B=0xFFFFFFFF, divide -> Lo=0x80000000, Hi=0.
- Prior Hi=0x11, Lo=0x22; A=5, B=0, DivStart -> Done and DivZero high in the cycle after E0; Hi/Lo unchanged; Busy never high.
- Reset=0 at iteration 10 of a multiply -> next cycle Busy=0, Hi=Lo=0, no Done. Then MultStart with A=3, B=4 -> Lo=12, Hi=0 after 34 cycles.
- Protocol corners:
  - MultStart and DivStart together -> multiply result.
  - MultStart pulsed again while Busy -> ignored.
  - Start in the DONE cycle -> second operation completes 34 cycles later, with no idle gap.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - Multicycle signed multiply/divide unit owning the HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MultStart,
    input  logic             DivStart,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    // Multiply: {partial product, remaining multiplier bits}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               divzero_q, divzero_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] div_sh;
    logic [WIDTH:0]     div_trial;
    logic               last_step;

    // Operand magnitudes, one datapath step of each algorithm, and the FSM next state
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = 1'b0;

        a_abs     = A[WIDTH-1] ? (~A + 1'b1) : A;
        b_abs     = B[WIDTH-1] ? (~B + 1'b1) : B;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        div_sh    = {acc_q[2*WIDTH-2:0], 1'b0};
        div_trial = {1'b0, div_sh[2*WIDTH-1:WIDTH]} - {1'b0, opnd_q};
        last_step = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (MultStart) begin
                    acc_d    = {{WIDTH{1'b0}}, b_abs};
                    opnd_d   = a_abs;
                    neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
                    is_div_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_MULT;
                end else if (DivStart) begin
                    if (B != '0) begin
                        acc_d     = {{WIDTH{1'b0}}, a_abs};
                        opnd_d    = b_abs;
                        neg_d     = A[WIDTH-1] ^ B[WIDTH-1];
                        rem_neg_d = A[WIDTH-1];
                        is_div_d  = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_DIV;
                    end else begin
                        // Zero divisor completes at once and leaves Hi/Lo untouched
                        divzero_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_MULT: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = S_FIX;
            end
            S_DIV: begin
                // Negative trial result means the divisor did not fit: restore by keeping the shift
                if (div_trial[WIDTH]) acc_d = div_sh;
                else                  acc_d = {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = S_DIV == S_DIV ? S_FIX : S_DIV;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q     ? (~acc_q[WIDTH-1:0] + 1'b1)       : acc_q[WIDTH-1:0];
                    hi_d = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_q ? (~acc_q + 1'b1) : acc_q;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears Hi/Lo
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
        end
    end

    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign Busy    = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign Done    = (state_q == S_DONE);
    assign DivZero = divzero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - Scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] A, B;
    logic        MultStart, DivStart;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivZero;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .A         (A),
        .B         (B),
        .MultStart (MultStart),
        .DivStart  (DivStart),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        int          busy;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: pops one expectation per Done pulse and checks result, flag, latency and busy length
    initial begin : monitor
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge Clk);
            if (Done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_hi"},   Hi, e.hi);
                    chk({e.name, "_lo"},   Lo, e.lo);
                    chk({e.name, "_dz"},   {31'b0, DivZero}, {31'b0, e.dz});
                    chk({e.name, "_cyc"},  cyc, e.cyc);
                    chk({e.name, "_busy"}, busy_run, e.busy);
                end
                busy_run = 0;
            end else if (Busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    // Drive a start at the current falling edge, queue the expectation, release start next edge
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic ms, input logic ds, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz, input int lat, input int ebusy);
        exp_t e;
        A = a; B = b; MultStart = ms; DivStart = ds;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + lat; e.busy = ebusy; e.name = name;
        sb.push_back(e);
        @(negedge Clk);
        MultStart = 1'b0; DivStart = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge Clk);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge Clk);
    endtask

    initial begin : stim
        int t;
        Reset = 1'b0; A = '0; B = '0; MultStart = 1'b0; DivStart = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_hi",   Hi, 32'h0);
        chk("rst_lo",   Lo, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_done", {31'b0, Done}, 32'h0);
        chk("rst_dz",   {31'b0, DivZero}, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        issue("mul_7_m3", 32'd7, 32'hFFFFFFFD, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34, 33);
        wait_idle();
        issue("div_100_m7", 32'd100, 32'hFFFFFFF9, 0, 1, 32'h00000002, 32'hFFFFFFF2, 0, 34, 33);
        wait_idle();
        issue("div_m7_2", 32'hFFFFFFF9, 32'd2, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34, 33);
        wait_idle();
        issue("mul_min_min", 32'h80000000, 32'h80000000, 1, 0, 32'h40000000, 32'h0, 0, 34, 33);
        wait_idle();
        issue("div_ovf", 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h0, 32'h80000000, 0, 34, 33);
        wait_idle();
        issue("div_preset", 32'h451, 32'h20, 0, 1, 32'h11, 32'h22, 0, 34, 33);
        wait_idle();
        issue("div_zero", 32'd5, 32'd0, 0, 1, 32'h11, 32'h22, 1, 1, 0);
        wait_idle();

        // Abort a multiply mid-flight: no Done may appear, Hi/Lo clear
        A = 32'h1234; B = 32'h10; MultStart = 1'b1;
        @(negedge Clk);
        MultStart = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_busy", {31'b0, Busy}, 32'h0);
        chk("abort_done", {31'b0, Done}, 32'h0);
        chk("abort_hi",   Hi, 32'h0);
        chk("abort_lo",   Lo, 32'h0);
        Reset = 1'b1;
        repeat (40) @(negedge Clk);
        issue("mul_3_4", 32'd3, 32'd4, 1, 0, 32'h0, 32'd12, 0, 34, 33);
        wait_idle();

        issue("both_start", 32'hFFFFFFFA, 32'd7, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 34, 33);
        wait_idle();

        // Starts and operand changes during the operation must not disturb it
        issue("start_busy", 32'd1000, 32'd1000, 1, 0, 32'h0, 32'h000F4240, 0, 34, 33);
        repeat (5) @(negedge Clk);
        A = 32'd2; B = 32'd2; MultStart = 1'b1; DivStart = 1'b1;
        @(negedge Clk);
        MultStart = 1'b0; DivStart = 1'b0; A = 32'hDEADBEEF; B = 32'h0;
        wait_idle();

        // Back-to-back: second start lands exactly in the Done cycle of the first
        t = cyc + 34;
        issue("b2b_first", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'h0, 32'h1, 0, 34, 33);
        for (int i = 0; i < 100 && cyc != t; i++) @(negedge Clk);
        issue("b2b_second", 32'hFFFFFF9C, 32'd7, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFF2, 0, 34, 33);
        wait_idle();

        repeat (5) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
